// File: rtl/attn_pkg.sv
// Shared attention-pipeline parameters, sizes and loader state encoding.
// Row/matrix helpers map a frame beat index to its destination register.
package attn_pkg;

  localparam int DATA_WIDTH  = 16;
  localparam int TOKEN_DIM   = 4;
  localparam int TOKEN_NUM   = 8;
  localparam int ROW_W       = DATA_WIDTH * TOKEN_DIM;
  localparam int MAT_W       = ROW_W * TOKEN_NUM;
  localparam int FRAME_BEATS = 3 * TOKEN_NUM;
  localparam int BEAT_W      = $clog2(FRAME_BEATS);
  localparam int ROW_IW      = $clog2(TOKEN_NUM);

  typedef enum logic [1:0] {
    FILL  = 2'd0,
    HOLD  = 2'd1,
    DRAIN = 2'd2
  } ld_state_t;

  typedef logic [BEAT_W-1:0] beat_t;

  localparam beat_t LAST_BEAT = BEAT_W'(FRAME_BEATS - 1);

  function automatic logic [1:0] mat_of(beat_t b);
    return 2'(int'(b) / TOKEN_NUM);
  endfunction

  function automatic logic [ROW_IW-1:0] row_of(beat_t b);
    return ROW_IW'(int'(b) % TOKEN_NUM);
  endfunction

endpackage

// File: rtl/qkv_stream_loader_if.sv
// Row stream in, assembled Q/K/V frame out, both valid/ready.
// slave is the loader's view, master the producer/consumer side.
interface qkv_stream_loader_if;
  import attn_pkg::*;

  logic [ROW_W-1:0] s_data;
  logic             s_valid;
  logic             s_last;
  logic             s_ready;
  logic [MAT_W-1:0] Q;
  logic [MAT_W-1:0] K;
  logic [MAT_W-1:0] V;
  logic             qkv_valid;
  logic             qkv_ready;

  modport slave (
    input  s_data, s_valid, s_last, qkv_ready,
    output s_ready, Q, K, V, qkv_valid
  );

  modport master (
    output s_data, s_valid, s_last, qkv_ready,
    input  s_ready, Q, K, V, qkv_valid
  );

endinterface

// File: rtl/qkv_stream_loader.sv
// Collects Q, K, V token rows into flat matrices and holds the frame
// until the consumer takes it; bad framing is flagged and dropped.
module qkv_stream_loader
  import attn_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  qkv_stream_loader_if.slave  bus,
  output logic                frame_err,
  output logic [7:0]          frame_cnt
);

  ld_state_t            state, state_nxt;
  beat_t                beat_idx, beat_nxt;
  logic                 beat;
  logic                 wr_en;
  logic                 err_nxt;
  logic                 cnt_inc;
  logic [2:0]           mat_en;
  logic [TOKEN_NUM-1:0] row_en;
  logic [MAT_W-1:0]     q_mat, k_mat, v_mat;

  assign bus.s_ready   = (state != HOLD);
  assign bus.qkv_valid = (state == HOLD);
  assign beat          = bus.s_valid && bus.s_ready;
  assign bus.Q         = q_mat;
  assign bus.K         = k_mat;
  assign bus.V         = v_mat;

  // State, beat counter, error pulse and frame counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FILL;
      beat_idx  <= '0;
      frame_err <= 1'b0;
      frame_cnt <= 8'd0;
    end else begin
      state     <= state_nxt;
      beat_idx  <= beat_nxt;
      frame_err <= err_nxt;
      if (cnt_inc) frame_cnt <= frame_cnt + 8'd1;
    end
  end

  // Next state: framing checks on the last-beat marker
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_idx;
    err_nxt   = 1'b0;
    cnt_inc   = 1'b0;
    wr_en     = 1'b0;
    unique case (state)
      FILL: begin
        if (beat) begin
          wr_en = 1'b1;
          if (beat_idx == LAST_BEAT) begin
            beat_nxt = '0;
            if (bus.s_last) begin
              state_nxt = HOLD;
            end else begin
              state_nxt = DRAIN;
              err_nxt   = 1'b1;
            end
          end else if (bus.s_last) begin
            beat_nxt = '0;
            err_nxt  = 1'b1;
          end else begin
            beat_nxt = beat_idx + 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.qkv_ready) begin
          state_nxt = FILL;
          cnt_inc   = 1'b1;
        end
      end
      DRAIN: begin
        if (beat && bus.s_last) begin
          state_nxt = FILL;
          beat_nxt  = '0;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Decode beat index into matrix and row write enables
  always_comb begin
    mat_en = '0;
    row_en = '0;
    if (wr_en) begin
      unique case (1'b1)
        (mat_of(beat_idx) == 2'd0): mat_en[0] = 1'b1;
        (mat_of(beat_idx) == 2'd1): mat_en[1] = 1'b1;
        (mat_of(beat_idx) == 2'd2): mat_en[2] = 1'b1;
        default: mat_en = '0;
      endcase
      row_en[row_of(beat_idx)] = 1'b1;
    end
  end

  // Row register banks for Q, K and V
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_mat <= '0;
      k_mat <= '0;
      v_mat <= '0;
    end else begin
      for (int r = 0; r < TOKEN_NUM; r++) begin
        if (row_en[r]) begin
          if (mat_en[0]) q_mat[r*ROW_W +: ROW_W] <= bus.s_data;
          if (mat_en[1]) k_mat[r*ROW_W +: ROW_W] <= bus.s_data;
          if (mat_en[2]) v_mat[r*ROW_W +: ROW_W] <= bus.s_data;
        end
      end
    end
  end

endmodule

// File: tb/tb_qkv_stream_loader.sv
// Scoreboard bench for qkv_stream_loader: good frames are queued as
// they are sent and compared when the loader presents them.
module tb_qkv_stream_loader;
  import attn_pkg::*;

  typedef struct packed {
    logic [MAT_W-1:0] q;
    logic [MAT_W-1:0] k;
    logic [MAT_W-1:0] v;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_err;
  logic [7:0] frame_cnt;

  qkv_stream_loader_if bus();

  qkv_stream_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .frame_err (frame_err),
    .frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;

  frame_t sb[$];
  frame_t cur;
  int     n_chk = 0;
  int     n_err = 0;
  int     err_seen = 0;
  int     exp_cnt = 0;
  int     e0;

  always @(posedge clk) if (frame_err) err_seen++;

  task automatic check(string tag, logic [MAT_W-1:0] got,
                       logic [MAT_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [ROW_W-1:0] row_data(int seed, int b);
    logic [ROW_W-1:0] r;
    for (int d = 0; d < TOKEN_DIM; d++)
      r[d*DATA_WIDTH +: DATA_WIDTH] = 16'((8*b + d)*256 + seed);
    return r;
  endfunction

  task automatic push_frame(int seed);
    frame_t e;
    e = '0;
    for (int b = 0; b < FRAME_BEATS; b++) begin
      int r;
      r = b % TOKEN_NUM;
      case (b / TOKEN_NUM)
        0: e.q[r*ROW_W +: ROW_W] = row_data(seed, b);
        1: e.k[r*ROW_W +: ROW_W] = row_data(seed, b);
        default: e.v[r*ROW_W +: ROW_W] = row_data(seed, b);
      endcase
    end
    sb.push_back(e);
  endtask

  task automatic send_beat(logic [ROW_W-1:0] d, logic last);
    int n = 0;
    while (!bus.s_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!bus.s_ready) check("rdy_to", MAT_W'(0), MAT_W'(1));
    bus.s_valid = 1'b1;
    bus.s_data  = d;
    bus.s_last  = last;
    @(posedge clk); #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_data  = $urandom();
  endtask

  task automatic send_beats(int seed, int nb, int last_at, bit gaps);
    for (int b = 0; b < nb; b++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 1) begin
          @(posedge clk); #1;
        end
        if (b == nb - 1) check("early_vld", MAT_W'(bus.qkv_valid), MAT_W'(0));
      end
      send_beat(row_data(seed, b), b == last_at);
    end
  endtask

  task automatic expect_frame();
    int n = 0;
    while (!bus.qkv_valid && n < 100) begin
      @(posedge clk); #1; n++;
    end
    check("vld_lat", MAT_W'(n), MAT_W'(0));
    check("vld", MAT_W'(bus.qkv_valid), MAT_W'(1));
    check("hold_rdy", MAT_W'(bus.s_ready), MAT_W'(0));
    if (sb.size() == 0) begin
      check("sb_empty", MAT_W'(0), MAT_W'(1));
    end else begin
      cur = sb.pop_front();
      check("Q", bus.Q, cur.q);
      check("K", bus.K, cur.k);
      check("V", bus.V, cur.v);
    end
  endtask

  task automatic accept();
    bus.qkv_ready = 1'b1;
    @(posedge clk); #1;
    bus.qkv_ready = 1'b0;
    exp_cnt = (exp_cnt + 1) % 256;
    check("rdy_back", MAT_W'(bus.s_ready), MAT_W'(1));
    check("vld_drop", MAT_W'(bus.qkv_valid), MAT_W'(0));
    check("cnt", MAT_W'(frame_cnt), MAT_W'(exp_cnt));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

  initial begin
    bus.s_valid   = 1'b0;
    bus.s_last    = 1'b0;
    bus.s_data    = '0;
    bus.qkv_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_Q", bus.Q, '0);
    check("rst_vld", MAT_W'(bus.qkv_valid), MAT_W'(0));
    check("rst_rdy", MAT_W'(bus.s_ready), MAT_W'(1));
    check("rst_err", MAT_W'(frame_err), MAT_W'(0));
    check("rst_cnt", MAT_W'(frame_cnt), MAT_W'(0));
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // ramp frame, held while consumer stalls
    push_frame(0);
    send_beats(0, FRAME_BEATS, FRAME_BEATS - 1, 1'b0);
    expect_frame();
    check("row0", MAT_W'(bus.Q[63:0]), MAT_W'(64'h0300_0200_0100_0000));
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("hold_Q", bus.Q, cur.q);
      check("hold_K", bus.K, cur.k);
      check("hold_V", bus.V, cur.v);
      check("hold_vld", MAT_W'(bus.qkv_valid), MAT_W'(1));
    end
    accept();

    // second clean frame
    push_frame(8'h11);
    send_beats(8'h11, FRAME_BEATS, FRAME_BEATS - 1, 1'b0);
    expect_frame();
    accept();

    // early last, then an immediate clean frame
    e0 = err_seen;
    send_beats(8'h22, 6, 5, 1'b0);
    check("early_err", MAT_W'(frame_err), MAT_W'(1));
    check("early_vld", MAT_W'(bus.qkv_valid), MAT_W'(0));
    push_frame(8'h33);
    send_beats(8'h33, FRAME_BEATS, FRAME_BEATS - 1, 1'b0);
    expect_frame();
    check("early_npulse", MAT_W'(err_seen - e0), MAT_W'(1));
    accept();

    // missing last, drain until marker, then clean frame
    e0 = err_seen;
    send_beats(8'h44, FRAME_BEATS, -1, 1'b0);
    check("miss_err", MAT_W'(frame_err), MAT_W'(1));
    check("drain_rdy", MAT_W'(bus.s_ready), MAT_W'(1));
    send_beats(8'h55, 3, 2, 1'b0);
    check("drain_vld", MAT_W'(bus.qkv_valid), MAT_W'(0));
    check("drain_npulse", MAT_W'(err_seen - e0), MAT_W'(1));
    push_frame(8'h66);
    send_beats(8'h66, FRAME_BEATS, FRAME_BEATS - 1, 1'b0);
    expect_frame();
    accept();

    // random s_valid gaps
    push_frame(8'h77);
    send_beats(8'h77, FRAME_BEATS, FRAME_BEATS - 1, 1'b1);
    expect_frame();
    accept();

    // asynchronous reset mid-frame
    send_beats(8'h88, 12, -1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("arst_Q", bus.Q, '0);
    check("arst_K", bus.K, '0);
    check("arst_V", bus.V, '0);
    check("arst_vld", MAT_W'(bus.qkv_valid), MAT_W'(0));
    check("arst_err", MAT_W'(frame_err), MAT_W'(0));
    check("arst_cnt", MAT_W'(frame_cnt), MAT_W'(0));
    check("arst_rdy", MAT_W'(bus.s_ready), MAT_W'(1));
    exp_cnt = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    e0 = err_seen;
    push_frame(8'h99);
    send_beats(8'h99, FRAME_BEATS, FRAME_BEATS - 1, 1'b0);
    expect_frame();
    accept();
    check("post_rst_err", MAT_W'(err_seen - e0), MAT_W'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/qkv_stream_loader.md
Name: qkv_stream_loader

Overview:
- Front end of the attention pipeline. Accepts Q, K and V one token row per beat over a valid/ready stream.
- Assembles the three full matrices into flat buses in the same layout the attention top consumes.
- Holds the complete frame stable under a valid/ready output handshake until the downstream consumer accepts it.
- Checks frame framing using a last-beat marker.

Parameters:
- DATA_WIDTH, 16, element width in Q8.8 fixed point. Data passes through unaltered; no arithmetic.
- TOKEN_DIM, 4, elements per token row.
- TOKEN_NUM, 8, tokens per matrix.

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_data  input  DATA_WIDTH*TOKEN_DIM  one token row; element d at bits [d*DATA_WIDTH +: DATA_WIDTH].
- s_valid  input  1  s_data and s_last are valid.
- s_last  input  1  marks the final beat of a frame.
- s_ready  output  1  loader can accept a beat.
- Q  output  DATA_WIDTH*TOKEN_DIM*TOKEN_NUM  assembled Q; row r at [r*DATA_WIDTH*TOKEN_DIM +: DATA_WIDTH*TOKEN_DIM].
- K  output  same width as Q  assembled K, same layout as Q.
- V  output  same width as Q  assembled V, same layout as Q.
- qkv_valid  output  1  Q, K and V hold a complete, well-framed frame.
- qkv_ready  input  1  consumer accepts the frame.
- frame_err  output  1  one-cycle pulse on a framing violation.
- frame_cnt  output  8  count of frames accepted downstream; wraps 255->0.

Behaviour:
- Beat = s_valid && s_ready at a rising edge. Frame = 3*TOKEN_NUM beats (24 at defaults), in order: Q rows 0..N-1, then K rows 0..N-1, then V rows 0..N-1.
- Beat counter beat_idx runs 0..3N-1:
  - matrix select = beat_idx / N
  - row = beat_idx % N
  - the selected row register is written on the beat.
- States:
  - FILL: s_ready=1, qkv_valid=0.
    - Beat with beat_idx=3N-1 and s_last=1: go to HOLD, beat_idx<=0.
    - Beat with s_last=1 and beat_idx<3N-1 (early last): frame_err pulse next cycle, beat_idx<=0, stay FILL; the frame is discarded.
    - Beat with beat_idx=3N-1 and s_last=0 (missing last): frame_err pulse next cycle, go to DRAIN, beat_idx<=0.
    - Any other beat: beat_idx++.
  - HOLD: s_ready=0, qkv_valid=1; Q/K/V frozen.
    - qkv_valid && qkv_ready: go to FILL next cycle, frame_cnt++.
    - Otherwise hold indefinitely.
  - DRAIN: s_ready=1, qkv_valid=0; beats are discarded and no registers are written.
    - Beat with s_last=1: go to FILL, beat_idx=0, no further frame_err.
- Outputs:
  - s_ready and qkv_valid are decoded combinationally from the state register only. No combinational path from any input to any output.
  - Latency: qkv_valid rises the cycle after the final beat. s_ready rises the cycle after the output handshake.
  - Throughput: one frame per 3N+1 cycles minimum; a 1-cycle bubble per frame is accepted.
- Q/K/V contents:
  - Q/K/V may change during FILL and DRAIN; their contents are valid only while qkv_valid=1.
  - After a discarded frame, rows keep stale or partial data; this is not an error.
- Reset, whether idle or mid-frame:
  - state=FILL, beat_idx=0, Q=K=V=0, frame_cnt=0, frame_err=0, qkv_valid=0.
  - s_ready=1 once the state is FILL. Upstream must not assert s_valid while rst_n=0.
  - A partial frame is lost without an error pulse.
- s_valid may stay high across cycles. With s_valid=0, state and counters do not change. s_data is ignored when s_valid=0.
- frame_err is registered, exactly one cycle per violation. Back-to-back early lasts give back-to-back pulses.

Decomposition:
- Shared package attn_pkg holds:
  - DATA_WIDTH, TOKEN_DIM, TOKEN_NUM
  - ROW_W=DATA_WIDTH*TOKEN_DIM
  - MAT_W=ROW_W*TOKEN_NUM
  - FRAME_BEATS=3*TOKEN_NUM
  - loader state encoding FILL/HOLD/DRAIN
- No sub-module: a single flat module with the state register, beat counter, three row-register banks written by a decoded row enable, and the frame counter.

Test Plan:
- Reset, then 24 beats of a 0x0100-style ramp (Q row r element d = 0x0100*(8r+d)), s_last on beat 23, qkv_ready=0 -> qkv_valid=1 the next cycle. Q row 0 = 0x0300_0200_0100_0000; K and V match their loaded rows. s_ready=0. Outputs stay stable for 10 cycles.
- From HOLD, pulse qkv_ready for 1 cycle -> s_ready=1 the next cycle, frame_cnt=1. A second full frame loads correctly and frame_cnt=2 after its acceptance.
- s_last on beat 5 -> frame_err pulse one cycle later, qkv_valid stays 0. An immediate new 24-beat frame completes normally.
- 24 beats with no s_last, then 3 more beats with s_last on the third -> one frame_err pulse only, beats dropped, then a clean frame is accepted.
- s_valid toggled randomly (about 50%) during a frame -> same Q/K/V result as the back-to-back case, and qkv_valid only after beat 24.
- rst_n asserted at beat 12 -> all outputs zero immediately (asynchronous). After release, a fresh 24-beat frame is accepted with no frame_err.
